// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline-control types and widths for the RV32I core
package riscv_pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int REG_IDX_W   = 5;
  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector (EX load feeding an ID source)
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  output logic                 hazard
);

  // x0 is never a real producer, so a load into x0 cannot create a dependency
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
             ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - PC redirect, flush shadow, load-use bubble and freeze control; BRANCH_HAZARD_PERF_CNT_EN adds event counters
module branch_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int XLEN        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_jump,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 stall_ext,
  output logic                 pc_sel,
  output logic [XLEN-1:0]      pc_target,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush
`ifdef BRANCH_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          redirect_cnt,
  output logic [31:0]          loaduse_cnt
`endif
);

  state_t                 state, state_n;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_n;
  logic                   hazard;
  logic                   take_redirect;
  logic                   take_loaduse;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // Event qualification: only RUN reacts to EX/ID, a redirect shadows any load-use
  always_comb begin
    take_redirect = !rst && !stall_ext && (state == RUN) && ex_valid && ex_jump;
    take_loaduse  = !rst && !stall_ext && (state == RUN) && !(ex_valid && ex_jump) && hazard;
  end

  // State register: flush_cnt counts the remaining shadow cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Next-state logic: a freeze holds everything, the shadow only advances on live cycles
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    if (!stall_ext) begin
      case (state)
        RUN: begin
          if (take_redirect && (FLUSH_DEPTH > 1)) begin
            state_n     = FLUSH;
            flush_cnt_n = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
          end
        end
        FLUSH: begin
          flush_cnt_n = flush_cnt - FLUSH_CNT_W'(1);
          if (flush_cnt == FLUSH_CNT_W'(1)) begin
            state_n = RUN;
          end
        end
        default: begin
          state_n     = RUN;
          flush_cnt_n = '0;
        end
      endcase
    end
  end

  // Output decode in priority order: reset, freeze, flush shadow, redirect, load-use
  always_comb begin
    pc_sel      = 1'b0;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      pc_sel = 1'b0;
    end else if (stall_ext) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (state == FLUSH) begin
      if_id_flush = 1'b1;
    end else if (take_redirect) begin
      pc_sel      = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (take_loaduse) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
    pc_target = pc_sel ? ex_target : '0;
  end

`ifdef BRANCH_HAZARD_PERF_CNT_EN
  // Event counters: wrap naturally at 2^32, frozen cycles never count
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt <= '0;
      loaduse_cnt  <= '0;
    end else begin
      if (take_redirect) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (take_loaduse) begin
        loaduse_cnt <= loaduse_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
